// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline constants, IF/ID state encoding and entry type
package pipe_pkg;
  localparam logic [15:0] NOP_INST_DEF = 16'h0800;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [15:0] pc_next;
    logic [15:0] instr;
    logic [15:0] pc;
  } if_id_t;
endpackage

// File: rtl/if_id_entry.sv
// if_id_entry: one IF/ID register entry (clk, clr -> {0,NOP,0}, ld, d_* in, held fields out)
module if_id_entry
  import pipe_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int INST_W = 16,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld,
  input  logic [PC_W-1:0]   d_pc_next,
  input  logic [INST_W-1:0] d_instr,
  input  logic [PC_W-1:0]   d_pc,
  output logic [PC_W-1:0]   pc_next,
  output logic [INST_W-1:0] instr,
  output logic [PC_W-1:0]   pc
);
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_next <= '0;
      instr   <= NOP_INST;
      pc      <= '0;
    end else if (ld) begin
      pc_next <= d_pc_next;
      instr   <= d_instr;
      pc      <= d_pc;
    end
  end
endmodule

// File: rtl/if_id_skid_reg.sv
// if_id_skid_reg: IF/ID register with valid/ready, one-entry skid, flush-to-NOP, stall counter (in_* fetch side, out_* decode side)
module if_id_skid_reg
  import pipe_pkg::*;
#(
  parameter int PC_W = 16,
  parameter int INST_W = 16,
  parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc_next,
  input  logic [INST_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc_next,
  output logic [INST_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic [CNT_W-1:0]  stall_cnt
);
  state_t state, nstate;
  logic in_fire, out_fire, clr, main_ld, skid_ld;
  logic [PC_W-1:0] m_pc_next, m_pc, s_pc_next, s_pc;
  logic [INST_W-1:0] m_instr, s_instr;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign clr      = rst | flush;
  always_ff @(posedge clk) state <= rst ? EMPTY : nstate;
  always_comb begin
    nstate = flush ? EMPTY :
             state == EMPTY ? (in_fire ? ONE : EMPTY) :
             state == ONE ? ((in_fire & ~out_fire) ? TWO : (~in_fire & out_fire) ? EMPTY : ONE) :
             (out_fire ? ONE : TWO);
  end
  always_comb begin
    in_ready    = (state != TWO) & ~flush;
    out_valid   = state != EMPTY;
    main_ld     = (state == TWO) ? out_fire : in_fire & ((state == EMPTY) | out_fire);
    skid_ld     = (state == ONE) & in_fire & ~out_fire;
    out_pc_next = out_valid ? m_pc_next : '0;
    out_instr   = out_valid ? m_instr : NOP_INST;
    out_pc      = out_valid ? m_pc : '0;
  end
  if_id_entry #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP_INST)) u_main (
    .clk(clk), .clr(clr), .ld(main_ld),
    .d_pc_next(state == TWO ? s_pc_next : in_pc_next),
    .d_instr(state == TWO ? s_instr : in_instr),
    .d_pc(state == TWO ? s_pc : in_pc),
    .pc_next(m_pc_next), .instr(m_instr), .pc(m_pc)
  );
  if_id_entry #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP_INST)) u_skid (
    .clk(clk), .clr(clr), .ld(skid_ld),
    .d_pc_next(in_pc_next), .d_instr(in_instr), .d_pc(in_pc),
    .pc_next(s_pc_next), .instr(s_instr), .pc(s_pc)
  );
  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (out_valid & ~out_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
